data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's data load/store port: the slave end of the load/store interface.
- Accepts one request at a time over a valid/ready handshake and performs a byte, halfword or word access on an internal word array.
- Returns load data or a write acknowledge after a programmable latency, with a valid/ready response handshake.
- Replaces the zero-latency combinational data RAM, so a multi-cycle memory can be modelled.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words (byte space 2^(ADDR_WIDTH+2)).
- LATENCY, 2, cycles from request acceptance to rspValid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  responder can accept a request.
- reqAddr  in  32  byte address.
- reqMode  in  4  [3]=write, [2:0]=funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- reqWData  in  32  store data, LSB-aligned.
- rspValid  out  1  response present.
- rspReady  in  1  consumer accepts the response.
- rspData  out  32  load result, extended to 32 bits; 0 for writes and errors.
- rspErr  out  1  access was rejected.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset: state=IDLE, reqReady=1, rspValid=0, rspErr=0, rspData=0, counter=0. Array contents are not cleared.
- Reset asserted mid-operation aborts the request. A write not yet committed is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid&&reqReady at edge T: capture addr/mode/wdata, load cnt=LATENCY-1, go to WAIT.
- WAIT:
  - reqReady=0.
  - At each edge: if cnt==0, perform the access and go to RESP; else cnt decrements.
  - rspValid therefore rises at edge T+LATENCY.
- RESP:
  - rspValid=1; rspData/rspErr are held stable.
  - On rspValid&&rspReady: go to IDLE, rspValid=0.
  - rspValid is held indefinitely under backpressure.
- reqReady is asserted only in IDLE, so at most one transaction is outstanding.
- Minimum throughput is one transaction per LATENCY+2 cycles.
- Access, performed at the WAIT->RESP edge:
  - Word index = addr[ADDR_WIDTH+1:2]. Byte order is little-endian; lane = addr[1:0].
  - Read b/bu: byte at the lane, sign-extended / zero-extended.
  - Read h/hu: halfword at addr[1]*16, sign-extended / zero-extended.
  - Read w: full word.
  - Write b: lane byte <- wdata[7:0]; other bytes unchanged.
  - Write h: halfword <- wdata[15:0]; other bytes unchanged.
  - Write w: full word <- wdata.
- Error conditions (rspErr=1, no array write, rspData=0):
  - h/hu with addr[0]=1.
  - w with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - Write with funct3 in {100,101}.
  - addr[31:ADDR_WIDTH+2] nonzero.
- Write responses: rspData=0, rspErr=0 on success.
- Read-after-write to the same address in the next transaction returns the new data (no hazard, since transactions are serialized).
- reqValid raised while not in IDLE is ignored until reqReady=1. The requester holds its request stable.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: error checking as above; rspErr is driven.
- Undefined:
  - rspErr is tied to 0.
  - Misaligned accesses are force-aligned: h ignores addr[0]; w ignores addr[1:0].
  - Out-of-range addresses wrap modulo the array size.
  - Illegal funct3 reads return 0; illegal funct3 writes do nothing.

Test Plan:
- Word store/load: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rspData=0xDEADBEEF, rspErr=0, rspValid exactly LATENCY cycles after each acceptance.
- Byte extension: after the word above, lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; sb 0x11 data 0x55 then lw 0x10 -> 0xDEAD55EF.
- Halfword: lh 0x12 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000DEAD; sh 0x10 data 0x1234 then lw 0x10 -> 0xDEAD1234.
- Errors (DMEM_ERR_EN defined): lw 0x11 -> rspErr=1, rspData=0, memory unchanged; sw to 0x00010000 with ADDR_WIDTH=10 -> rspErr=1, no write.
- Backpressure: rspReady=0 for 5 cycles -> rspValid and rspData held stable, reqReady=0; rspReady=1 -> IDLE next edge, reqReady=1.
- Reset mid-WAIT: issue sw 0x20 data 0xA5A5A5A5, assert rst_n=0 before commit -> outputs return to reset values asynchronously; subsequent lw 0x20 returns prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-port memory responder: serialized byte/half/word loads and stores with LATENCY-cycle response.
// Define DMEM_ERR_EN for access checking; otherwise accesses are force-aligned and wrapped, and rspErr stays 0.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqAddr,
  input  logic [3:0]  reqMode,
  input  logic [31:0] reqWData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspErr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_cnt;
  logic [31:0]             r_addr, r_wdata, r_rdata;
  logic [3:0]              r_mode;
  logic                    r_err;
  logic [31:0]             r_mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_word, w_new, w_rd, w_rdata;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [2:0]              w_f3;
  logic                    w_wr, w_bad, w_we, w_err, w_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (reqValid) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
      RESP:    if (rspReady) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reqReady = (r_state == IDLE);
    rspValid = (r_state == RESP);
  end

  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_f3     = r_mode[2:0];
  assign w_wr     = r_mode[3];
  assign w_idx    = r_addr[ADDR_WIDTH+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_byte   = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half   = r_addr[1] ? w_word[31:16] : w_word[15:0];

  // Decode the captured request into load result, merged store word and a reject flag.
  always_comb begin
    w_rd  = 32'd0;
    w_new = w_word;
    w_bad = 1'b0;
    case (w_f3)
      3'b000, 3'b100: begin
        w_rd = w_f3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_new[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end
      3'b001, 3'b101: begin
        w_rd = w_f3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        w_new[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      3'b010:  begin
        w_rd  = w_word;
        w_new = r_wdata;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_wr && w_f3[2]) w_bad = 1'b1;
`ifdef DMEM_ERR_EN
    if (w_f3[1:0] == 2'b01 && r_addr[0])          w_bad = 1'b1;
    if (w_f3 == 3'b010 && r_addr[1:0] != 2'b00)   w_bad = 1'b1;
    if (|r_addr[31:ADDR_WIDTH+2])                 w_bad = 1'b1;
`endif
  end

`ifdef DMEM_ERR_EN
  assign w_err = w_bad;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^r_addr[31:ADDR_WIDTH+2];
  assign w_err       = 1'b0;
`endif

  assign w_we    = w_wr && !w_bad;
  assign w_rdata = (w_wr || w_bad) ? 32'd0 : w_rd;

  // Capture stage: request latched on acceptance, latency counter drives the commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && reqValid) r_cnt <= 4'(LATENCY - 1);
      else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_commit) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && reqValid) begin
      r_addr  <= reqAddr;
      r_mode  <= reqMode;
      r_wdata <= reqWData;
    end
  end

  // Commit stage: array is written only at the WAIT->RESP edge, so a reset in WAIT discards the store.
  always_ff @(posedge clk) begin
    if (w_commit && w_we) r_mem[w_idx] <= w_new;
  end

  assign rspData = r_rdata;
  assign rspErr  = r_err;

endmodule
